// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter, next-PC select and fetch handshake with boot delay
//
// Registers the fetch PC and selects the next PC from the branch comparator result and the
// jump controls from decode. A boot-delay FSM holds off the first fetch for BOOT_DELAY
// cycles after reset release.
//
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned jump/branch targets to
// TRAP_VEC and park the unit in a TRAP state until reset.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   stall           hold the PC; overrides imem_ready
//   branch_taken    conditional branch taken, target pc + imm
//   jal             unconditional jump, target pc + imm
//   jalr            register jump, target (rs1_data + imm) with bit 0 cleared
//   imm, rs1_data   immediate and register operand from decode
//   imem_ready      instruction memory returned the word at pc this cycle
//   pc, pc_plus4    current fetch address and its sequential successor
//   imem_valid      fetch request valid
//   retire          instruction at pc completed, PC advances at the next edge
//   redirect        the PC update is non-sequential
//   misalign_trap   sticky misaligned-target trap flag

module pc_next_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY = 2,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_valid,
    output logic        retire,
    output logic        redirect,
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1
`ifdef MISALIGN_TRAP_EN
        ,
        S_TRAP = 2'd2
`endif
    } state_t;

    // BOOT_DELAY of 0 and 1 both leave BOOT on the first edge after reset release.
    localparam logic [3:0] BOOT_LAST = (BOOT_DELAY == 0) ? 4'd0 : 4'(BOOT_DELAY - 1);

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] seq_pc;
    logic [31:0] rel_target;
    logic [31:0] jalr_target;
    logic [31:0] next_pc;
    logic        non_seq;

`ifdef MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
`endif

    assign seq_pc      = pc_q + 32'd4;
    assign rel_target  = pc_q + imm;
    assign jalr_target = (rs1_data + imm) & 32'hFFFF_FFFE;
    assign non_seq     = jalr | jal | branch_taken;

    always_comb begin
        next_pc = seq_pc;
        if (jalr) begin
            next_pc = jalr_target;
        end else if (jal || branch_taken) begin
            next_pc = rel_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
`ifdef MISALIGN_TRAP_EN
        trap_d     = trap_q;
`endif
        imem_valid = 1'b0;
        retire     = 1'b0;
        redirect   = 1'b0;

        case (state_q)
            S_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                imem_valid = 1'b1;
                // Control inputs are only sampled on a step; stall masks everything.
                if (imem_ready && !stall) begin
                    retire   = 1'b1;
                    redirect = non_seq;
                    pc_d     = next_pc;
`ifdef MISALIGN_TRAP_EN
                    // Only non-sequential targets are checked; +4 keeps alignment.
                    if (non_seq && (next_pc[1:0] != 2'b00)) begin
                        pc_d    = TRAP_VEC;
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            S_TRAP: begin
                // Parked until reset; pc already holds TRAP_VEC.
            end
`endif
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
`ifdef MISALIGN_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = seq_pc;

`ifdef MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`else
    assign misalign_trap = 1'b0;
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage that sits directly downstream of the branch comparator.
- Consumes its branch_taken result, together with the jump controls from decode, and computes and registers the next PC.
- Drives the instruction-memory fetch handshake.
- Holds a boot-delay FSM so the first fetch starts a fixed number of cycles after reset release.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_DELAY, 2, cycles spent in BOOT after reset release before the first fetch; range 0..15.
- TRAP_VEC, 32'h0000_0100, redirect target on a misaligned target (only used when MISALIGN_TRAP_EN is defined).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the PC; the current instruction does not retire.
- branch_taken  in  1  conditional branch resolved taken; target = pc + imm.
- jal  in  1  unconditional jump; target = pc + imm.
- jalr  in  1  register jump; target = (rs1_data + imm) & 32'hFFFF_FFFE.
- imm  in  32  sign-extended immediate from decode.
- rs1_data  in  32  register operand for jalr.
- imem_ready  in  1  instruction memory has returned the word at pc this cycle.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational, used for link writeback.
- imem_valid  out  1  fetch request valid.
- retire  out  1  1-cycle pulse: the instruction at pc completed and the PC advances.
- redirect  out  1  1-cycle pulse: the PC update is non-sequential.
- misalign_trap  out  1  sticky trap flag; driven 0 when MISALIGN_TRAP_EN is not defined.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=BOOT; boot counter=0.
  - imem_valid=0, retire=0, redirect=0, misalign_trap=0.
  - Applies immediately at any point, including mid-fetch or mid-redirect. No pending update survives reset.
- FSM states: BOOT, RUN (plus TRAP when the optional feature is enabled).
- BOOT:
  - imem_valid=0; the counter increments each clk.
  - Transition to RUN on the cycle the counter reaches BOOT_DELAY-1.
  - With BOOT_DELAY=0, RUN is entered on the first clk edge after reset release.
- RUN:
  - imem_valid=1.
  - A step occurs when imem_valid && imem_ready && !stall.
  - On a step, pc is loaded with next_pc at the clock edge, and retire pulses high in the same cycle as the step (combinational from the step condition).
  - No step: pc holds; retire=0; redirect=0.
- next_pc priority, highest first:
  - jalr → (rs1_data+imm) & ~1.
  - jal → pc+imm.
  - branch_taken → pc+imm.
  - otherwise → pc+4.
  - Simultaneous jalr/jal/branch_taken assertions resolve by this priority, with no error.
- redirect is 1 on a step whose source is jalr, jal or branch_taken, else 0. It is combinational with retire.
- Latency: the new pc is visible 1 cycle after the step cycle.
- stall:
  - Overrides imem_ready. Control inputs are ignored that cycle, and decode must hold them stable until the step.
  - stall in BOOT has no effect on the counter.
- Arithmetic: all adds are 32-bit modulo 2^32, carry discarded.
  - Example: pc=32'hFFFF_FFFC sequential step → 32'h0000_0000.
  - Example: imm=32'hFFFF_FFF8 from pc=32'h0000_0004 → 32'hFFFF_FFFC.
- pc_plus4 always equals pc+4 mod 2^32, in all states including reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On a step where the selected next_pc has next_pc[1:0]≠0, pc loads TRAP_VEC instead, redirect=1, misalign_trap goes to 1 and the FSM enters TRAP.
  - TRAP: imem_valid=0, pc holds TRAP_VEC. Only reset exits TRAP.
  - Sequential (+4) steps never trap.
- Not defined:
  - Misaligned targets load as computed, with only bit0 cleared for jalr.
  - misalign_trap is tied 0 and the TRAP state does not exist.

Test Plan:
- Reset release with BOOT_DELAY=2, imem_ready=1 → imem_valid=0 for 2 cycles, then 1; pc sequence 0x0, 0x4, 0x8; retire high each RUN cycle; redirect=0.
- pc=0x40, branch_taken=1, imm=0xFFFF_FFF0, step → next pc=0x30, redirect=1 for one cycle; then with branch_taken=0 → pc=0x34.
- jalr=1, jal=1 and branch_taken=1 together, rs1_data=0x1001, imm=0x10, pc=0x80 → pc=0x1010 (jalr wins, bit0 cleared); pc_plus4=0x84 during the step cycle.
- stall=1 for 3 cycles with jal=1, imm=0x100 at pc=0x200 → pc holds 0x200 and retire=0 throughout; stall drops → pc=0x300 the next cycle.
- pc=0xFFFF_FFFC, sequential step → pc=0x0000_0000; rst_n pulsed low mid-RUN with pc=0x58 → pc=RESET_PC immediately and imem_valid=0 until BOOT completes.
- MISALIGN_TRAP_EN defined, jal=1, imm=0x6, pc=0x10 → pc=TRAP_VEC (0x100), misalign_trap=1, imem_valid=0 held until reset.
